snd_cmd_encoder: RTL and testbench

Command-side encoder for the TMS9919-compatible sound generator. Accepts high-level sound commands (channel, kind, 10-bit value) over a valid/ready handshake and buffers them in a 4-entry FIFO. Serialises each command into the chip's latch/data byte protocol as single-cycle `snd_we` pulses on `snd_data`, with a minimum spacing between writes. It sits between the CPU/sequencer side and the sound chip's `we`/`data_in` port.

---
 rtl/snd_cmd_encoder.sv | 153 +++++++++++++++
 tb/tb_snd_cmd_encoder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snd_cmd_encoder.sv
// Command-side encoder for a TMS9919-compatible sound generator: buffers high-level
// sound commands in a small FIFO and serialises them into spaced latch/data byte writes.
module snd_cmd_encoder #(
   parameter int GAP_CYCLES = 28,
   parameter bit COMPACT    = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_chan,
   input  logic       cmd_kind,
   input  logic [9:0] cmd_value,
   output logic       snd_we,
   output logic [7:0] snd_data,
   output logic       busy,
   output logic [2:0] fifo_level
);

   typedef enum logic [1:0] {IDLE, DECODE, WAIT_L, WAIT_D} state_e;

   localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

   state_e            state_q, state_d;
   logic [3:0][12:0]  mem_q, mem_d;
   logic [1:0]        wr_ptr_q, wr_ptr_d;
   logic [1:0]        rd_ptr_q, rd_ptr_d;
   logic [2:0]        level_q, level_d;
   logic [12:0]       cmd_q, cmd_d;
   logic [7:0]        gap_q, gap_d;
   logic [7:0]        snd_data_q, snd_data_d;
   logic              sh_valid_q, sh_valid_d;
   logic [2:0]        sh_reg_q, sh_reg_d;
   logic [3:0]        sh_low_q, sh_low_d;
   logic              push, pop;
   logic              cmd_tone, shadow_hit;
   logic [7:0]        latch_byte, data_byte;

   assign cmd_ready  = (level_q != 3'd4);
   assign push       = cmd_valid & cmd_ready;
   assign fifo_level = level_q;
   assign busy       = (level_q != 3'd0) | (state_q != IDLE) | (gap_q != 8'd0);

   // Command register layout: [12:11] channel, [10] kind, [9:0] value; [12:10] is the chip register.
   assign latch_byte = {1'b1, cmd_q[12:10], cmd_q[3:0]};
   assign data_byte  = {2'b00, cmd_q[9:4]};
   assign cmd_tone   = ~cmd_q[10] & (cmd_q[12:11] != 2'd3);
   assign shadow_hit = COMPACT & cmd_tone & sh_valid_q &
                       (sh_reg_q == cmd_q[12:10]) & (sh_low_q == cmd_q[3:0]);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) begin
         mem_d[wr_ptr_q] = {cmd_chan, cmd_kind, cmd_value};
         wr_ptr_d        = wr_ptr_q + 2'd1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 2'd1;
      end
      case ({push, pop})
         2'b10:   level_d = level_q + 3'd1;
         2'b01:   level_d = level_q - 3'd1;
         default: level_d = level_q;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      cmd_d      = cmd_q;
      pop        = 1'b0;
      snd_we     = 1'b0;
      snd_data_d = snd_data_q;
      sh_valid_d = sh_valid_q;
      sh_reg_d   = sh_reg_q;
      sh_low_d   = sh_low_q;
      case (state_q)
         IDLE: begin
            if (level_q != 3'd0) begin
               pop     = 1'b1;
               cmd_d   = mem_q[rd_ptr_q];
               state_d = DECODE;
            end
         end
         DECODE: begin
            state_d = shadow_hit ? WAIT_D : WAIT_L;
         end
         WAIT_L: begin
            if (gap_q == 8'd0) begin
               snd_we     = 1'b1;
               snd_data_d = latch_byte;
               sh_valid_d = 1'b1;
               sh_reg_d   = cmd_q[12:10];
               sh_low_d   = cmd_q[3:0];
               state_d    = cmd_tone ? WAIT_D : IDLE;
            end
         end
         WAIT_D: begin
            if (gap_q == 8'd0) begin
               snd_we     = 1'b1;
               snd_data_d = data_byte;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // The byte appears in the same cycle as its strobe and is held by snd_data_q afterwards.
   assign snd_data = snd_data_d;

   always_comb begin
      gap_d = gap_q;
      if (snd_we) begin
         gap_d = GAP_LOAD;
      end else if (gap_q != 8'd0) begin
         gap_d = gap_q - 8'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         wr_ptr_q   <= 2'd0;
         rd_ptr_q   <= 2'd0;
         level_q    <= 3'd0;
         gap_q      <= 8'd0;
         snd_data_q <= 8'h00;
         sh_valid_q <= 1'b0;
         sh_reg_q   <= 3'd0;
         sh_low_q   <= 4'd0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         gap_q      <= gap_d;
         snd_data_q <= snd_data_d;
         sh_valid_q <= sh_valid_d;
         sh_reg_q   <= sh_reg_d;
         sh_low_q   <= sh_low_d;
      end
   end

   // FIFO storage and the command register carry no reset; occupancy and state guard them.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      cmd_q <= cmd_d;
   end

endmodule

// File: tb/tb_snd_cmd_encoder.sv
// Directed bench for snd_cmd_encoder: one compacting instance and one non-compacting
// instance share command fields; byte writes are logged on the falling edge.
module tb_snd_cmd_encoder;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_valid0 = 1'b0;
   logic [1:0] cmd_chan = 2'd0;
   logic       cmd_kind = 1'b0;
   logic [9:0] cmd_value = 10'd0;

   logic       cmd_ready, snd_we, busy;
   logic [7:0] snd_data;
   logic [2:0] fifo_level;
   logic       cmd_ready0, snd_we0, busy0;
   logic [7:0] snd_data0;
   logic [2:0] fifo_level0;

   int         cyc = 0;
   int         n_cmp = 0;
   int         n_fail = 0;
   logic [7:0] pq_data[$];
   int         pq_cyc[$];
   logic [7:0] q0_data[$];
   int         consec_err = 0;
   int         stab_err = 0;
   logic       prev_we = 1'b0;
   logic [7:0] last_data = 8'h00;

   snd_cmd_encoder #(.GAP_CYCLES(28), .COMPACT(1'b1)) u_dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_chan(cmd_chan), .cmd_kind(cmd_kind), .cmd_value(cmd_value),
      .snd_we(snd_we), .snd_data(snd_data), .busy(busy), .fifo_level(fifo_level)
   );

   snd_cmd_encoder #(.GAP_CYCLES(28), .COMPACT(1'b0)) u_dut0 (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
      .cmd_chan(cmd_chan), .cmd_kind(cmd_kind), .cmd_value(cmd_value),
      .snd_we(snd_we0), .snd_data(snd_data0), .busy(busy0), .fifo_level(fifo_level0)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (reset) begin
         prev_we   = 1'b0;
         last_data = 8'h00;
      end else begin
         if (snd_we) begin
            if (prev_we) consec_err++;
            pq_data.push_back(snd_data);
            pq_cyc.push_back(cyc);
            last_data = snd_data;
         end else if (snd_data !== last_data) begin
            stab_err++;
         end
         prev_we = snd_we;
         if (snd_we0) q0_data.push_back(snd_data0);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_logs();
      pq_data.delete();
      pq_cyc.delete();
      q0_data.delete();
   endtask

   task automatic send(input int tgt, input logic [1:0] ch, input logic k,
                       input logic [9:0] v, output int t);
      int n;
      n = 0;
      @(negedge clk);
      while (((tgt == 0) ? !cmd_ready : !cmd_ready0) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) begin
         n_cmp++; n_fail++;
         $display("FAIL send_ready: cmd_ready stayed low for %0d cycles, required high", n);
      end
      cmd_chan  = ch;
      cmd_kind  = k;
      cmd_value = v;
      if (tgt == 0) cmd_valid = 1'b1;
      else          cmd_valid0 = 1'b1;
      t = cyc;
      @(negedge clk);
      cmd_valid  = 1'b0;
      cmd_valid0 = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while ((busy || busy0) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) begin
         n_cmp++; n_fail++;
         $display("FAIL %s_idle: busy still %b/%b after %0d cycles, required 0", name, busy, busy0, n);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++; if (snd_we !== 1'b0) begin n_fail++; $display("FAIL rst_hold_we: got %b want 0", snd_we); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_hold_busy: got %b want 0", busy); end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (snd_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b want 0", snd_we); end
      n_cmp++; if (snd_data !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h want 00", snd_data); end
      n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", cmd_ready); end
      n_cmp++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL rst_level: got %0d want 0", fifo_level); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
   endtask

   task automatic test_tone();
      int t;
      logic [7:0] e[2] = '{8'hAE, 8'h1F};
      clear_logs();
      send(0, 2'd1, 1'b0, 10'h1FE, t);
      n_cmp++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL tone_level: got %0d want 1", fifo_level); end
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL tone_busy: got %b want 1", busy); end
      wait_idle("tone");
      n_cmp++; if (pq_data.size() != 2) begin n_fail++; $display("FAIL tone_count: got %0d want 2", pq_data.size()); end
      for (int i = 0; i < 2 && i < pq_data.size(); i++) begin
         n_cmp++; if (pq_data[i] !== e[i]) begin n_fail++; $display("FAIL tone_byte%0d: got %h want %h", i, pq_data[i], e[i]); end
      end
      if (pq_cyc.size() >= 2) begin
         n_cmp++; if (pq_cyc[0] != t + 3) begin n_fail++; $display("FAIL tone_latency: got %0d want %0d", pq_cyc[0] - t, 3); end
         n_cmp++; if (pq_cyc[1] - pq_cyc[0] != 28) begin n_fail++; $display("FAIL tone_gap: got %0d want 28", pq_cyc[1] - pq_cyc[0]); end
      end
   endtask

   task automatic test_compact();
      int t;
      logic [7:0] e2[2] = '{8'hA0, 8'h2F};
      logic [7:0] e0[4] = '{8'hAE, 8'h1F, 8'hAE, 8'h2F};
      clear_logs();
      send(0, 2'd1, 1'b0, 10'h2FE, t);
      wait_idle("cmp_a");
      n_cmp++; if (pq_data.size() != 1) begin n_fail++; $display("FAIL cmp_a_count: got %0d want 1", pq_data.size()); end
      if (pq_data.size() >= 1) begin
         n_cmp++; if (pq_data[0] !== 8'h2F) begin n_fail++; $display("FAIL cmp_a_byte: got %h want 2f", pq_data[0]); end
         n_cmp++; if (pq_cyc[0] != t + 3) begin n_fail++; $display("FAIL cmp_a_latency: got %0d want 3", pq_cyc[0] - t); end
      end
      clear_logs();
      send(0, 2'd1, 1'b0, 10'h2F0, t);
      wait_idle("cmp_b");
      n_cmp++; if (pq_data.size() != 2) begin n_fail++; $display("FAIL cmp_b_count: got %0d want 2", pq_data.size()); end
      for (int i = 0; i < 2 && i < pq_data.size(); i++) begin
         n_cmp++; if (pq_data[i] !== e2[i]) begin n_fail++; $display("FAIL cmp_b_byte%0d: got %h want %h", i, pq_data[i], e2[i]); end
      end
      clear_logs();
      send(1, 2'd1, 1'b0, 10'h1FE, t);
      send(1, 2'd1, 1'b0, 10'h2FE, t);
      wait_idle("nocmp");
      n_cmp++; if (q0_data.size() != 4) begin n_fail++; $display("FAIL nocmp_count: got %0d want 4", q0_data.size()); end
      for (int i = 0; i < 4 && i < q0_data.size(); i++) begin
         n_cmp++; if (q0_data[i] !== e0[i]) begin n_fail++; $display("FAIL nocmp_byte%0d: got %h want %h", i, q0_data[i], e0[i]); end
      end
   endtask

   task automatic test_single();
      int t;
      logic [7:0] e[5] = '{8'hD5, 8'hE5, 8'hAE, 8'h2F, 8'hFF};
      clear_logs();
      send(0, 2'd2, 1'b1, 10'h005, t);
      send(0, 2'd3, 1'b0, 10'h005, t);
      send(0, 2'd1, 1'b0, 10'h2FE, t);
      send(0, 2'd3, 1'b1, 10'h00F, t);
      wait_idle("single");
      n_cmp++; if (pq_data.size() != 5) begin n_fail++; $display("FAIL single_count: got %0d want 5", pq_data.size()); end
      for (int i = 0; i < 5 && i < pq_data.size(); i++) begin
         n_cmp++; if (pq_data[i] !== e[i]) begin n_fail++; $display("FAIL single_byte%0d: got %h want %h", i, pq_data[i], e[i]); end
      end
      for (int i = 1; i < pq_cyc.size(); i++) begin
         n_cmp++; if (pq_cyc[i] - pq_cyc[i-1] != 28) begin n_fail++; $display("FAIL single_gap%0d: got %0d want 28", i, pq_cyc[i] - pq_cyc[i-1]); end
      end
   endtask

   task automatic test_fifo_full();
      int t0, i, drop, s;
      logic accept;
      logic [1:0] vc[6] = '{2'd0, 2'd0, 2'd2, 2'd1, 2'd3, 2'd0};
      logic       vk[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [9:0] vv[6] = '{10'h123, 10'h153, 10'h007, 10'h3C4, 10'h002, 10'h163};
      logic [7:0] e[9]  = '{8'h83, 8'h12, 8'h15, 8'hD7, 8'hA4, 8'h3C, 8'hE2, 8'h83, 8'h16};
      clear_logs();
      i = 0;
      drop = -1;
      @(negedge clk);
      t0 = cyc;
      for (int n = 0; n < 400 && drop < 0; n++) begin
         if (i < 6) begin
            cmd_chan = vc[i]; cmd_kind = vk[i]; cmd_value = vv[i]; cmd_valid = 1'b1;
         end else begin
            cmd_valid = 1'b0;
         end
         if (cyc == t0 + 5) begin
            n_cmp++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL full_level: got %0d want 4", fifo_level); end
            n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", cmd_ready); end
            n_cmp++; if (i != 5) begin n_fail++; $display("FAIL full_accepted: got %0d want 5", i); end
         end
         accept = cmd_valid & cmd_ready;
         @(negedge clk);
         if (accept) i++;
         if (i == 6 && !busy && drop < 0) drop = cyc;
      end
      cmd_valid = 1'b0;
      n_cmp++; if (i != 6) begin n_fail++; $display("FAIL full_all_accepted: got %0d want 6", i); end
      n_cmp++; if (pq_data.size() != 9) begin n_fail++; $display("FAIL full_count: got %0d want 9", pq_data.size()); end
      for (int k = 0; k < 9 && k < pq_data.size(); k++) begin
         n_cmp++; if (pq_data[k] !== e[k]) begin n_fail++; $display("FAIL full_byte%0d: got %h want %h", k, pq_data[k], e[k]); end
      end
      if (pq_cyc.size() >= 1) begin
         n_cmp++; if (pq_cyc[0] != t0 + 3) begin n_fail++; $display("FAIL full_latency: got %0d want 3", pq_cyc[0] - t0); end
      end
      for (int k = 1; k < pq_cyc.size(); k++) begin
         n_cmp++; if (pq_cyc[k] - pq_cyc[k-1] != 28) begin n_fail++; $display("FAIL full_gap%0d: got %0d want 28", k, pq_cyc[k] - pq_cyc[k-1]); end
      end
      n_cmp++;
      if (drop < 0 || pq_cyc.size() == 0) begin
         n_fail++; $display("FAIL full_busy_drop: busy never fell (drop=%0d), required fall after last gap", drop);
      end else begin
         s = pq_cyc[pq_cyc.size() - 1];
         if (drop < s + 28 || drop > s + 29) begin
            n_fail++; $display("FAIL full_busy_drop: fell %0d cycles after last strobe, required 28..29", drop - s);
         end
      end
   endtask

   task automatic test_mid_reset();
      int t, n;
      clear_logs();
      send(0, 2'd1, 1'b0, 10'h1FE, t);
      send(0, 2'd2, 1'b1, 10'h005, t);
      n = 0;
      while (pq_data.size() < 1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         n_cmp++; n_fail++; $display("FAIL mrst_first: no latch strobe within %0d cycles, required one", n);
      end
      repeat (5) @(negedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      n_cmp++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL mrst_level: got %0d want 0", fifo_level); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mrst_busy: got %b want 0", busy); end
      n_cmp++; if (snd_we !== 1'b0) begin n_fail++; $display("FAIL mrst_we: got %b want 0", snd_we); end
      @(negedge clk);
      reset = 1'b0;
      repeat (60) @(negedge clk);
      n_cmp++; if (pq_data.size() != 1) begin n_fail++; $display("FAIL mrst_aborted: got %0d strobes want 1", pq_data.size()); end
      if (pq_data.size() >= 1) begin
         n_cmp++; if (pq_data[0] !== 8'hAE) begin n_fail++; $display("FAIL mrst_latch: got %h want ae", pq_data[0]); end
      end
      clear_logs();
      send(0, 2'd1, 1'b0, 10'h1FE, t);
      wait_idle("mrst_after");
      n_cmp++; if (pq_data.size() != 2) begin n_fail++; $display("FAIL mrst_after_count: got %0d want 2", pq_data.size()); end
      if (pq_data.size() >= 2) begin
         n_cmp++; if (pq_data[0] !== 8'hAE) begin n_fail++; $display("FAIL mrst_after_latch: got %h want ae", pq_data[0]); end
         n_cmp++; if (pq_data[1] !== 8'h1F) begin n_fail++; $display("FAIL mrst_after_data: got %h want 1f", pq_data[1]); end
         n_cmp++; if (pq_cyc[0] != t + 3) begin n_fail++; $display("FAIL mrst_after_latency: got %0d want 3", pq_cyc[0] - t); end
      end
   endtask

   task automatic test_protocol();
      n_cmp++; if (consec_err != 0) begin n_fail++; $display("FAIL proto_consecutive_we: got %0d events want 0", consec_err); end
      n_cmp++; if (stab_err != 0) begin n_fail++; $display("FAIL proto_data_stable: got %0d changes want 0", stab_err); end
   endtask

   initial begin
      test_reset();
      test_tone();
      test_compact();
      test_single();
      test_fifo_full();
      test_mid_reset();
      test_protocol();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
